// File: rtl/aes_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_ctrl_pkg
//
// Shared definitions for the AES CTR-mode sequencing logic: the block width,
// the default counter width, the scheduler state encoding and a helper that
// assembles a {nonce, counter} block for an arbitrary counter width.
// Used by ctr_reg_unit and ctr_stream_sched.
// ---------------------------------------------------------------------------
package aes_ctrl_pkg;

    localparam int BLOCK_W       = 128;
    localparam int CTR_W_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KINIT,
        ST_KWAIT,
        ST_STREAM,
        ST_ENC,
        ST_EWAIT,
        ST_OUT
    } sched_state_t;

    // Both fields arrive zero-extended to the block width; the counter is
    // masked to ctr_w bits and the nonce is shifted above it.
    function automatic logic [BLOCK_W-1:0] make_ctr_block(
        input logic [BLOCK_W-1:0] nonce,
        input logic [BLOCK_W-1:0] ctr,
        input int                 ctr_w
    );
        logic [BLOCK_W-1:0] mask;
        mask = {BLOCK_W{1'b1}} >> (BLOCK_W - ctr_w);
        return (nonce << ctr_w) | (ctr & mask);
    endfunction

endpackage

// File: rtl/ctr_reg_unit.sv
// ---------------------------------------------------------------------------
// ctr_reg_unit
//
// Nonce/counter register for CTR mode. Loading captures a new nonce and
// restarts the counter at CTR_INIT; incrementing advances the counter modulo
// 2^CTR_W and records a wrap in a sticky overflow flag that the next load
// clears. Written to be shared with a decryption-side scheduler.
//
// Ports:
//   i_clk     system clock
//   i_reset   synchronous, active-high reset
//   i_load    capture i_nonce, counter <= CTR_INIT, clear overflow
//   i_nonce   nonce value (BLOCK_W-CTR_W bits)
//   i_inc     advance the counter by one
//   o_block   {nonce_reg, ctr_reg}
//   o_ovf     sticky: the counter wrapped since the last load
// ---------------------------------------------------------------------------
module ctr_reg_unit
    import aes_ctrl_pkg::*;
#(
    parameter int               CTR_W    = CTR_W_DEFAULT,
    parameter logic [CTR_W-1:0] CTR_INIT = '0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_load,
    input  logic [BLOCK_W-CTR_W-1:0] i_nonce,
    input  logic                     i_inc,
    output logic [BLOCK_W-1:0]       o_block,
    output logic                     o_ovf
);

    logic [BLOCK_W-CTR_W-1:0] r_nonce;
    logic [CTR_W-1:0]         r_ctr;
    logic                     r_ovf;

    // Load wins over increment; the scheduler never asks for both at once.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_nonce <= '0;
            r_ctr   <= CTR_INIT;
            r_ovf   <= 1'b0;
        end else if (i_load) begin
            r_nonce <= i_nonce;
            r_ctr   <= CTR_INIT;
            r_ovf   <= 1'b0;
        end else if (i_inc) begin
            r_ctr <= r_ctr + CTR_W'(1);
            if (&r_ctr) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_block = make_ctr_block(BLOCK_W'(r_nonce), BLOCK_W'(r_ctr), CTR_W);
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/ctr_stream_sched.sv
// ---------------------------------------------------------------------------
// ctr_stream_sched
//
// CTR-mode sequencer in front of a shared AES encryption core. Runs key
// expansion on request, then takes 128-bit payload beats, forms the counter
// block {nonce, ctr}, kicks the core for one block and returns
// payload XOR keystream on the output stream.
//
// Optional feature (macro CTR_PREFETCH_EN): a one-entry keystream buffer.
// While idle inside a message the next counter block is encrypted ahead of
// time, so a beat arriving with the buffer full is answered the next cycle.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_key_init          one-cycle key expansion request
//   i_nonce             message nonce, sampled on a message's first beat
//   i_in_valid/o_in_ready/i_in_data/i_in_last     payload input stream
//   o_out_valid/i_out_ready/o_out_data/o_out_last result output stream
//   o_core_init         one-cycle key expansion pulse to the core
//   o_core_next         one-cycle block encryption pulse to the core
//   o_core_block        {nonce_reg, ctr_reg} presented to the core
//   i_core_result       keystream block from the core
//   i_core_ready        core idle / result valid
//   o_key_valid         key expansion has completed
//   o_ctr_ovf           sticky: counter wrapped within the current message
// ---------------------------------------------------------------------------
module ctr_stream_sched
    import aes_ctrl_pkg::*;
#(
    parameter int               CTR_W    = CTR_W_DEFAULT,
    parameter logic [CTR_W-1:0] CTR_INIT = '0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_key_init,
    input  logic [BLOCK_W-CTR_W-1:0] i_nonce,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [BLOCK_W-1:0]       i_in_data,
    input  logic                     i_in_last,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [BLOCK_W-1:0]       o_out_data,
    output logic                     o_out_last,
    output logic                     o_core_init,
    output logic                     o_core_next,
    output logic [BLOCK_W-1:0]       o_core_block,
    input  logic [BLOCK_W-1:0]       i_core_result,
    input  logic                     i_core_ready,
    output logic                     o_key_valid,
    output logic                     o_ctr_ovf
);

    sched_state_t       r_state;
    logic               r_key_valid;
    logic               r_core_init;
    logic               r_core_next;
    logic               r_out_valid;
    logic [BLOCK_W-1:0] r_out_data;
    logic               r_out_last;
    logic [BLOCK_W-1:0] r_beat_data;
    logic               r_beat_last;
    logic               r_msg_first;

`ifdef CTR_PREFETCH_EN
    logic [BLOCK_W-1:0] r_ks_buf;
    logic               r_buf_valid;
    logic               r_pf_active;
`endif

    logic w_in_ready;
    logic w_accept;
    logic w_load;
    logic w_inc;

    // A key_init request in STREAM takes priority, so the beat must not be
    // acknowledged in that same cycle.
    assign w_in_ready = (r_state == ST_STREAM) && !i_key_init;
    assign w_accept   = w_in_ready && i_in_valid;
    assign w_load     = w_accept && r_msg_first;
    assign w_inc      = (r_state == ST_EWAIT) && i_core_ready;

    ctr_reg_unit #(
        .CTR_W    (CTR_W),
        .CTR_INIT (CTR_INIT)
    ) u_ctr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_nonce (i_nonce),
        .i_inc   (w_inc),
        .o_block (o_core_block),
        .o_ovf   (o_ctr_ovf)
    );

    // Main sequencer. ENC and KINIT are guard cycles: the core only drops
    // core_ready one cycle after seeing its pulse, so ready is not trusted
    // until the following state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_key_valid <= 1'b0;
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_beat_data <= '0;
            r_beat_last <= 1'b0;
            r_msg_first <= 1'b1;
`ifdef CTR_PREFETCH_EN
            r_ks_buf    <= '0;
            r_buf_valid <= 1'b0;
            r_pf_active <= 1'b0;
`endif
        end else begin
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_key_init) begin
                        r_core_init <= 1'b1;
                        r_key_valid <= 1'b0;
                        r_state     <= ST_KINIT;
                    end
                end

                ST_KINIT: begin
                    r_state <= ST_KWAIT;
                end

                ST_KWAIT: begin
                    if (i_core_ready) begin
                        r_key_valid <= 1'b1;
                        r_state     <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (i_key_init) begin
                        r_core_init <= 1'b1;
                        r_key_valid <= 1'b0;
                        r_state     <= ST_KINIT;
`ifdef CTR_PREFETCH_EN
                        r_buf_valid <= 1'b0;
`endif
                    end else if (i_in_valid) begin
                        r_beat_data <= i_in_data;
                        r_beat_last <= i_in_last;
                        r_msg_first <= 1'b0;
`ifdef CTR_PREFETCH_EN
                        // Either the buffer is consumed now or it was already
                        // empty; in both cases nothing stays buffered.
                        r_buf_valid <= 1'b0;
                        if (r_buf_valid) begin
                            r_out_data  <= i_in_data ^ r_ks_buf;
                            r_out_last  <= i_in_last;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_OUT;
                        end else begin
                            r_core_next <= 1'b1;
                            r_state     <= ST_ENC;
                        end
`else
                        r_core_next <= 1'b1;
                        r_state     <= ST_ENC;
`endif
                    end
`ifdef CTR_PREFETCH_EN
                    // msg_first=1 means the next block belongs to a message
                    // whose nonce is not known yet, so never prefetch then.
                    else if (!r_buf_valid && !r_msg_first) begin
                        r_core_next <= 1'b1;
                        r_pf_active <= 1'b1;
                        r_state     <= ST_ENC;
                    end
`endif
                end

                ST_ENC: begin
                    r_state <= ST_EWAIT;
                end

                ST_EWAIT: begin
                    if (i_core_ready) begin
`ifdef CTR_PREFETCH_EN
                        if (r_pf_active) begin
                            r_ks_buf    <= i_core_result;
                            r_buf_valid <= 1'b1;
                            r_pf_active <= 1'b0;
                            r_state     <= ST_STREAM;
                        end else begin
                            r_out_data  <= r_beat_data ^ i_core_result;
                            r_out_last  <= r_beat_last;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_OUT;
                        end
`else
                        r_out_data  <= r_beat_data ^ i_core_result;
                        r_out_last  <= r_beat_last;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
`endif
                    end
                end

                ST_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_msg_first <= 1'b1;
                        end
                        r_state <= ST_STREAM;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_core_init = r_core_init;
    assign o_core_next = r_core_next;
    assign o_key_valid = r_key_valid;

endmodule

// File: tb/tb_ctr_stream_sched.sv
// ---------------------------------------------------------------------------
// tb_ctr_stream_sched
//
// Two schedulers are driven in lockstep from the same stream inputs: one with
// the default 64-bit counter and one with an 8-bit counter starting at 8'hFE
// so that counter wrap shows up within a short message. Each has its own
// behavioural AES core model whose keystream is a fixed function of the
// counter block.
// ---------------------------------------------------------------------------
module tb_ctr_stream_sched;
    import aes_ctrl_pkg::*;

    localparam int KEY_LAT = 10;
    localparam int ENC_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset    = 1'b1;
    logic         keyInit  = 1'b0;
    logic         inValid  = 1'b0;
    logic         inLast   = 1'b0;
    logic         outReady = 1'b0;
    logic [127:0] inData   = '0;
    logic [63:0]  nonceA   = '0;
    logic [119:0] nonceB;
    assign nonceB = {56'h0, nonceA};

    logic         inReadyA, outValidA, outLastA, coreInitA, coreNextA, keyValidA, ctrOvfA;
    logic [127:0] outDataA, coreBlockA;
    logic         inReadyB, outValidB, outLastB, coreInitB, coreNextB, keyValidB, ctrOvfB;
    logic [127:0] outDataB, coreBlockB;

    logic         coreRdyA = 1'b1, coreRdyB = 1'b1;
    logic [127:0] coreResA = '0, coreResB = '0;
    logic [127:0] latchA = '0, latchB = '0;
    int           cntA = 0, cntB = 0;

    int totalCount = 0;
    int badCount   = 0;

    ctr_stream_sched dutA (
        .i_clk(clk), .i_reset(reset), .i_key_init(keyInit), .i_nonce(nonceA),
        .i_in_valid(inValid), .o_in_ready(inReadyA), .i_in_data(inData), .i_in_last(inLast),
        .o_out_valid(outValidA), .i_out_ready(outReady), .o_out_data(outDataA), .o_out_last(outLastA),
        .o_core_init(coreInitA), .o_core_next(coreNextA), .o_core_block(coreBlockA),
        .i_core_result(coreResA), .i_core_ready(coreRdyA), .o_key_valid(keyValidA), .o_ctr_ovf(ctrOvfA)
    );

    ctr_stream_sched #(.CTR_W(8), .CTR_INIT(8'hFE)) dutB (
        .i_clk(clk), .i_reset(reset), .i_key_init(keyInit), .i_nonce(nonceB),
        .i_in_valid(inValid), .o_in_ready(inReadyB), .i_in_data(inData), .i_in_last(inLast),
        .o_out_valid(outValidB), .i_out_ready(outReady), .o_out_data(outDataB), .o_out_last(outLastB),
        .o_core_init(coreInitB), .o_core_next(coreNextB), .o_core_block(coreBlockB),
        .i_core_result(coreResB), .i_core_ready(coreRdyB), .o_key_valid(keyValidB), .o_ctr_ovf(ctrOvfB)
    );

    function automatic logic [127:0] ks(input logic [127:0] b);
        return {b[63:0], b[127:64]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    // Core models: ready drops the edge after a pulse, stays low for the
    // latency, then comes back together with the keystream of the block
    // captured at the pulse.
    always @(posedge clk) begin
        if (coreInitA) begin
            coreRdyA <= 1'b0; cntA <= KEY_LAT;
        end else if (coreNextA) begin
            coreRdyA <= 1'b0; cntA <= ENC_LAT; latchA <= coreBlockA;
        end else if (cntA > 0) begin
            cntA <= cntA - 1;
            if (cntA == 1) begin coreRdyA <= 1'b1; coreResA <= ks(latchA); end
        end
    end

    always @(posedge clk) begin
        if (coreInitB) begin
            coreRdyB <= 1'b0; cntB <= KEY_LAT;
        end else if (coreNextB) begin
            coreRdyB <= 1'b0; cntB <= ENC_LAT; latchB <= coreBlockB;
        end else if (cntB > 0) begin
            cntB <= cntB - 1;
            if (cntB == 1) begin coreRdyB <= 1'b1; coreResB <= ks(latchB); end
        end
    end

    typedef struct {
        logic [63:0]  nonce;
        logic [127:0] data;
        logic         last;
        int           stall;
        logic [63:0]  ctr;
        logic         ovfB;
    } vec_t;

    typedef struct {
        logic [127:0] dataA;
        logic [127:0] dataB;
        logic         last;
        logic         ovfB;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic pushExpected(input logic [63:0] nonce, input logic [127:0] data,
                                input logic last, input logic [63:0] ctr, input logic ovfB);
        exp_t e;
        logic [7:0] ctrB;
        ctrB    = 8'hFE + ctr[7:0];
        e.dataA = data ^ ks({nonce, ctr});
        e.dataB = data ^ ks({56'h0, nonce, ctrB});
        e.last  = last;
        e.ovfB  = ovfB;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic applyStimulus(input logic [63:0] nonce, input logic [127:0] data,
                                 input logic last, output bit accepted);
        int k;
        nonceA  = nonce;
        inData  = data;
        inLast  = last;
        inValid = 1'b1;
        k = 0;
        while (!inReadyA && k < 300) begin
            @(negedge clk);
            k++;
        end
        accepted = inReadyA;
        if (!accepted) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL accept_timeout: got no in_ready expected in_ready within 300 cycles");
        end else begin
            checkFlag("lockstep_in_ready", inReadyB, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        inValid = 1'b0;
    endtask

    task automatic waitKey();
        for (int k = 0; k < 60 && !keyValidA; k++) @(negedge clk);
        checkFlag("key_ready", keyValidA, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() > 0; k++) @(negedge clk);
        checkOutput("scoreboard_drained", 128'(sb.size()), 128'(0));
    endtask

    // Output side: applies the configured stall, checks held data during the
    // stall and compares each accepted beat against the scoreboard.
    int   stallCfg = 0;
    int   stallLeft = 0;
    logic holdActive = 1'b0;
    logic [127:0] holdA = '0;

    always @(negedge clk) begin
        exp_t e;
        if (reset || !outValidA) begin
            outReady   = 1'b0;
            stallLeft  = stallCfg;
            holdActive = 1'b0;
        end else begin
            if (!holdActive) begin
                holdA      = outDataA;
                holdActive = 1'b1;
            end else begin
                checkOutput("held_data", outDataA, holdA);
            end
            if (stallLeft > 0) begin
                outReady = 1'b0;
                stallLeft--;
            end else begin
                outReady = 1'b1;
                if (sb.size() == 0) begin
                    totalCount++;
                    badCount++;
                    $display("[TB] FAIL unexpected_out: got beat %h expected none", outDataA);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data_a", outDataA, e.dataA);
                    checkOutput("out_data_b", outDataB, e.dataB);
                    checkFlag("out_last_a", outLastA, e.last);
                    checkFlag("out_last_b", outLastB, e.last);
                    checkFlag("ctr_ovf_b", ctrOvfB, e.ovfB);
                end
                holdActive = 1'b0;
                stallLeft  = stallCfg;
            end
        end
    end

    initial begin
        bit          acc;
        logic [63:0] curNonce;
        logic        firstBeat;
        logic [7:0]  ctrB;
        int          initPulses, readyRose, kvIdx, nextCount;
        logic        leak, prevRdy, sawValid, sawReady;

        vecs[0] = '{nonce:64'hA5A5_0000_0000_0001, data:128'h0, last:1'b1, stall:0, ctr:64'd0, ovfB:1'b0};
        vecs[1] = '{nonce:64'h1111_2222_3333_4444, data:128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
                    last:1'b0, stall:5, ctr:64'd0, ovfB:1'b0};
        vecs[2] = '{nonce:64'h9999_9999_9999_9999, data:128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0,
                    last:1'b0, stall:5, ctr:64'd1, ovfB:1'b1};
        vecs[3] = '{nonce:64'h9999_9999_9999_9999, data:128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001,
                    last:1'b1, stall:5, ctr:64'd2, ovfB:1'b1};
        vecs[4] = '{nonce:64'h0BAD_CAFE_0000_7777, data:128'hAAAA_5555_AAAA_5555_CCCC_3333_CCCC_3333,
                    last:1'b0, stall:1, ctr:64'd0, ovfB:1'b0};
        vecs[5] = '{nonce:64'h0000_0000_0000_0000, data:128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0,
                    last:1'b1, stall:0, ctr:64'd1, ovfB:1'b1};

        repeat (3) @(negedge clk);
        checkFlag("rst_in_ready", inReadyA, 1'b0);
        checkFlag("rst_out_valid", outValidA, 1'b0);
        checkFlag("rst_key_valid", keyValidA, 1'b0);
        checkFlag("rst_core_init", coreInitA, 1'b0);
        checkFlag("rst_core_next", coreNextA, 1'b0);
        checkFlag("rst_ctr_ovf", ctrOvfA, 1'b0);
        checkOutput("rst_out_data", outDataA, 128'h0);
        checkOutput("rst_core_block_a", coreBlockA, 128'h0);
        checkOutput("rst_core_block_b", coreBlockB, {120'h0, 8'hFE});

        reset   = 1'b0;
        inValid = 1'b1;
        @(negedge clk);
        checkFlag("idle_in_ready", inReadyA, 1'b0);
        inValid = 1'b0;

        // Key expansion with detailed timing checks.
        keyInit = 1'b1;
        @(negedge clk);
        keyInit    = 1'b0;
        initPulses = 0;
        readyRose  = -1;
        kvIdx      = -1;
        leak       = 1'b0;
        prevRdy    = coreRdyA;
        for (int k = 0; k < 40; k++) begin
            if (coreInitA) initPulses++;
            if (inReadyA && !keyValidA) leak = 1'b1;
            if (coreRdyA && !prevRdy && readyRose < 0) readyRose = k;
            if (keyValidA && kvIdx < 0) kvIdx = k;
            prevRdy = coreRdyA;
            @(negedge clk);
        end
        checkOutput("core_init_pulses", 128'(initPulses), 128'(1));
        checkFlag("in_ready_before_key", leak, 1'b0);
        checkOutput("key_valid_timing", 128'(kvIdx), 128'(readyRose + 1));
        checkFlag("key_valid_b", keyValidB, 1'b1);

        // Table-driven messages.
        firstBeat = 1'b1;
        curNonce  = '0;
        for (int i = 0; i < 6; i++) begin
            stallCfg = vecs[i].stall;
            if (firstBeat) curNonce = vecs[i].nonce;
            ctrB = 8'hFE + vecs[i].ctr[7:0];
            pushExpected(curNonce, vecs[i].data, vecs[i].last, vecs[i].ctr, vecs[i].ovfB);
            applyStimulus(vecs[i].nonce, vecs[i].data, vecs[i].last, acc);
            if (acc) begin
                checkFlag("core_next", coreNextA, 1'b1);
                checkOutput("core_block_a", coreBlockA, {curNonce, vecs[i].ctr});
                checkOutput("core_block_b", coreBlockB, {56'h0, curNonce, ctrB});
                if (firstBeat) checkFlag("ovf_cleared_on_first", ctrOvfB, 1'b0);
            end
            firstBeat = vecs[i].last;
        end
        drain();
        checkFlag("ovf_a_never", ctrOvfA, 1'b0);

        // key_init beats a simultaneous in_valid in STREAM.
        stallCfg = 0;
        inData   = 128'h5A5A;
        inLast   = 1'b1;
        inValid  = 1'b1;
        keyInit  = 1'b1;
        #1;
        checkFlag("keyinit_priority_ready", inReadyA, 1'b0);
        @(negedge clk);
        keyInit = 1'b0;
        inValid = 1'b0;
        checkFlag("keyinit_pulse", coreInitA, 1'b1);
        checkFlag("keyinit_clears_valid", keyValidA, 1'b0);
        waitKey();

        // Reset while waiting on the core.
        pushExpected(64'h7777_0000_0000_0001, 128'hC0FFEE, 1'b1, 64'd0, 1'b0);
        applyStimulus(64'h7777_0000_0000_0001, 128'hC0FFEE, 1'b1, acc);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkFlag("rst_ewait_out_valid", outValidA, 1'b0);
        checkFlag("rst_ewait_key_valid", keyValidA, 1'b0);
        checkFlag("rst_ewait_in_ready", inReadyA, 1'b0);
        reset = 1'b0;
        sb.delete();
        inValid  = 1'b1;
        sawValid = 1'b0;
        sawReady = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (outValidA) sawValid = 1'b1;
            if (inReadyA) sawReady = 1'b1;
        end
        inValid = 1'b0;
        checkFlag("stale_result_ignored", sawValid, 1'b0);
        checkFlag("idle_after_reset", sawReady, 1'b0);

        keyInit = 1'b1;
        @(negedge clk);
        keyInit = 1'b0;
        waitKey();
        pushExpected(64'h2222_0000_0000_00AA, 128'h0123, 1'b1, 64'd0, 1'b0);
        applyStimulus(64'h2222_0000_0000_00AA, 128'h0123, 1'b1, acc);
        drain();

        // Two-beat message with a long gap between the beats.
        pushExpected(64'h3333_4444_5555_6666, 128'hABCD_0001, 1'b0, 64'd0, 1'b0);
        applyStimulus(64'h3333_4444_5555_6666, 128'hABCD_0001, 1'b0, acc);
        drain();
        repeat (20) @(negedge clk);
        pushExpected(64'h3333_4444_5555_6666, 128'hABCD_0002, 1'b1, 64'd1, 1'b1);
        applyStimulus(64'h3333_4444_5555_6666, 128'hABCD_0002, 1'b1, acc);
`ifdef CTR_PREFETCH_EN
        checkFlag("pf_fast_out_valid", outValidA, 1'b1);
        checkFlag("pf_no_next_at_accept", coreNextA, 1'b0);
`else
        checkFlag("gap_out_valid_not_early", outValidA, 1'b0);
`endif
        nextCount = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (coreNextA) nextCount++;
        end
        checkOutput("no_next_after_last", 128'(nextCount), 128'(0));
        drain();

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/ctr_stream_sched.md
Name: ctr_stream_sched

Overview:
- CTR-mode sequencer for the shared AES encryption core.
- Accepts 128-bit payload beats on a valid/ready stream and forms the counter block {nonce, ctr}.
- Pulses the core's next, waits for the keystream, then emits payload XOR keystream on an output stream.
- Also sequences key expansion (core init) and blocks traffic until the key is ready.

Parameters:
- CTR_W, 64, counter field width; the nonce field is 128-CTR_W bits.
- CTR_INIT, 0, counter value loaded at the start of each message.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- key_init  in  1  one-cycle request to run key expansion
- nonce  in  128-CTR_W  message nonce, sampled on the first beat of each message
- in_valid  in  1  payload beat valid
- in_ready  out  1  payload beat accepted when in_valid and in_ready are both high
- in_data  in  128  plaintext or ciphertext beat
- in_last  in  1  final beat of the message
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accept
- out_data  out  128  in_data XOR keystream
- out_last  out  1  copy of in_last for this beat
- core_init  out  1  one-cycle pulse to the core/key memory
- core_next  out  1  one-cycle pulse to start one block encryption
- core_block  out  128  {nonce_reg, ctr_reg}; held stable while the core is busy
- core_result  in  128  keystream block; valid while core_ready is high after completion
- core_ready  in  1  core idle / result valid
- key_valid  out  1  high once key expansion has completed
- ctr_ovf  out  1  sticky: counter wrapped within a message

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, ctr_reg=CTR_INIT, message-start flag msg_first=1.
- States: IDLE, KINIT, KWAIT, STREAM, ENC, EWAIT, OUT.
- IDLE:
  - key_init -> pulse core_init, clear key_valid -> KINIT.
  - STREAM is unreachable until key_valid=1; in_ready=0 in IDLE.
- KINIT: one guard cycle in which core_ready is ignored, since the core drops ready one cycle after init -> KWAIT.
- KWAIT: core_ready=1 -> key_valid=1 -> STREAM.
- STREAM:
  - in_ready=1.
  - On accept: latch in_data and in_last.
  - If msg_first, latch nonce_reg=nonce, set ctr_reg=CTR_INIT, clear ctr_ovf, clear msg_first.
  - Pulse core_next on the cycle after accept -> ENC.
  - key_init has priority over in_valid on the same cycle; it goes to KINIT and the beat is not accepted.
- ENC: guard cycle -> EWAIT.
- EWAIT:
  - core_ready=1 -> out_data=beat XOR core_result, out_valid=1 -> OUT.
  - ctr_reg increments modulo 2^CTR_W in the same cycle.
  - Wrap from all-ones to 0 sets ctr_ovf.
- OUT:
  - Hold out_* stable until out_ready.
  - On accept: if out_last, set msg_first=1. Go to STREAM.
- key_init outside IDLE/STREAM is ignored; no request queuing.
- Latency: accept to out_valid = 4 cycles plus core latency; throughput is 1 beat per core pass.
- Reset mid-operation returns to IDLE immediately with key_valid=0. The key must be reloaded.
- core_block always reflects {nonce_reg, ctr_reg}.

Optional Feature:
- Macro CTR_PREFETCH_EN.
- When defined:
  - A single 128-bit keystream buffer is added.
  - In STREAM with the buffer empty and msg_first=0, the block issues core_next for ctr_reg without waiting for input. The result fills the buffer and ctr_reg increments.
  - A beat accepted while the buffer is full produces out_valid the next cycle, skipping ENC/EWAIT.
  - The buffer is invalidated on in_last acceptance, key_init, and reset.
  - Prefetch never crosses a message boundary.
- When undefined: behaviour is exactly as above; no buffer is present.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - FSM state enum
  - BLOCK_W=128
  - default CTR_W
  - helper function make_ctr_block(nonce, ctr)
- Sub-module ctr_reg_unit: nonce/counter register with load, increment, and overflow detect. Reused by a future decryption-side scheduler.

Test Plan:
- Key init: pulse key_init; core model drops ready for 10 cycles -> exactly one core_init pulse, key_valid rises 1 cycle after core_ready, in_ready=0 throughout.
- Single-beat message:
  - Stimulus: nonce=64'hA5A5_0000_0000_0001, in_data=0, in_last=1.
  - Response: core_block=128'hA5A5_0000_0000_0001_0000_0000_0000_0000, out_data=core_result, out_last=1.
- Three-beat message with out_ready stalled 5 cycles per beat -> counter fields 0,1,2 on core_block, out_data held stable during stalls, no beat loss.
- Counter wrap:
  - Stimulus: CTR_W=8, CTR_INIT=8'hFE, 3 beats.
  - Response: counters FE, FF, 00; ctr_ovf=1 after the third beat; ctr_ovf cleared on the first beat of the next message.
- Reset in EWAIT -> next cycle: state IDLE, out_valid=0, key_valid=0, in_ready=0; the pending core result is ignored.
- With CTR_PREFETCH_EN:
  - Stimulus: 2-beat message with a 20-cycle gap between beats.
  - Response: the second beat's out_valid arrives 1 cycle after accept, and no core_next is issued after the in_last beat.
